// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   uart_state_e        : receiver FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS           : payload bits per frame (8N1)
//   SYNC_STAGES         : flop depth of the input synchronizer
//   half_period_reload(): counter reload that lands the first sample in the
//                         middle of the start bit
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    // Counting down from this value to zero takes half a bit period, so the
    // start bit is re-checked at its midpoint. Every later bit is then one
    // full period further on and is also sampled at its midpoint.
    function automatic int half_period_reload(input int clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Flop-chain synchronizer for asynchronous inputs (SYNC_STAGES deep, two by
// default). Each bit is synchronized independently, so only use it for
// single-bit or otherwise glitch-tolerant signals.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL into every stage
//   i_d   : asynchronous input
//   o_q   : synchronized output
// ----------------------------------------------------------------------------
module sync_2ff
    import uart_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    // Reset to the line's idle level so leaving reset never looks like an
    // edge on the synchronized signal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its neighbour held before the edge, which is what builds a chain
            // of flops; blocking assignments would collapse it into one flop.
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver. The serial line is synchronized, each bit is sampled at
// its midpoint, and completed bytes are presented on data_o together with a
// one-cycle valid_o strobe. A stop bit sampled low gives a one-cycle
// frame_err_o strobe instead. count_o counts good bytes and wraps at 256.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   ena         : block enable; low forces the receiver idle and discards any
//                 partial frame (data_o and count_o hold their values)
//   rx_i        : raw asynchronous serial line, idle high
//   data_o      : last correctly received byte, stable until the next one
//   valid_o     : one-cycle strobe, data_o updated this cycle
//   frame_err_o : one-cycle strobe, stop bit was sampled low
//   busy_o      : a frame is in progress (FSM not in IDLE)
//   count_o     : number of good bytes received, modulo 256
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit, even, 4..4096
//   CNT_W        : bit-period counter width, 2**CNT_W > CLKS_PER_BIT
// ----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o,
    output logic [7:0] count_o
);

    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(half_period_reload(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer: every decision below uses w_rx_s only.
    // ------------------------------------------------------------------
    logic w_rx_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx_i),
        .o_q   (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    // Frame-end outcome, registered so the output stage updates on the edge
    // after the stop bit is sampled.
    logic                 r_good_pend;
    logic                 r_err_pend;

    uart_state_e          w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_bit_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_good;
    logic                 w_err;
    logic                 w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statement leaves one unassigned and no
        // latch is inferred.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_good        = 1'b0;
        w_err         = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A low level is enough to start; the start bit is confirmed
                // half a period later, which rejects short glitches.
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_RELOAD;
                end
            end

            START: begin
                if (w_cnt_zero) begin
                    if (!w_rx_s) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                        w_cnt_nxt     = FULL_RELOAD;
                    end else begin
                        // False start: the line went high again before the
                        // middle of the start bit.
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            DATA: begin
                if (w_cnt_zero) begin
                    // LSB arrives first, so shift in from the top; after eight
                    // samples bit 0 has reached the bottom.
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nxt   = FULL_RELOAD;
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            STOP: begin
                if (w_cnt_zero) begin
                    // Back to IDLE at once: a start bit straight after the
                    // stop bit is accepted, and a line still low after a
                    // framing error is treated as a fresh start.
                    w_state_nxt = IDLE;
                    if (w_rx_s) begin
                        w_good = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Disable wins over everything: drop the partial frame, clear the
        // counters and suppress any outcome.
        if (!ena) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_bit_idx_nxt = '0;
            w_good        = 1'b0;
            w_err         = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            // NOTE: the shift register is pure datapath and could be left
            // unreset, but clearing it keeps a reset-mid-frame from leaving
            // stale bits visible anywhere; it costs one reset net on 8 flops.
            r_shift     <= '0;
            r_good_pend <= 1'b0;
            r_err_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_good_pend <= w_good;
            r_err_pend  <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: byte register, strobes and good-byte counter
    // ------------------------------------------------------------------
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;
    logic [7:0] r_count;

    // The pending flags are mutually exclusive by construction, so valid_o
    // and frame_err_o can never be high together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_count     <= 8'h00;
        end else begin
            r_valid     <= r_good_pend & ena;
            r_frame_err <= r_err_pend & ena;
            if (r_good_pend && ena) begin
                r_data  <= r_shift;
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign count_o     = r_count;
    assign busy_o      = (r_state != IDLE);

endmodule : uart_rx_byte

// File: tb/tb_uart_rx_byte.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_byte
// Directed-plus-random bench for uart_rx_byte at CLKS_PER_BIT = 16. Frames
// are driven as a serial waveform; a reference model built from the frame
// format predicts, per frame, the strobe type, data_o, count_o and the cycle
// the strobe should appear. A negedge monitor records what the DUT produced.
// ----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int CPB = 16;
    // Edges from the first edge that sees rx_i low to the strobe: two
    // synchronizer flops, half a bit to the start-bit middle, nine more bits
    // to the stop-bit middle, one edge to register the outcome.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;
    logic [7:0] count_o;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [7:0] cnt;
        logic       err;
    } ev_t;

    ev_t act_q[$];
    ev_t exp_q[$];

    int n_assert    = 0;
    int n_fail      = 0;
    int overlap     = 0;
    int busy_cycles = 0;

    // Reference model state: what data_o / count_o should hold.
    logic [7:0] m_data  = 8'h00;
    logic [7:0] m_count = 8'h00;

    // Monitor: sample outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (valid_o && frame_err_o) overlap <= overlap + 1;
        if (busy_o) busy_cycles <= busy_cycles + 1;
        if (valid_o)     act_q.push_back('{cyc, data_o, count_o, 1'b0});
        if (frame_err_o) act_q.push_back('{cyc, data_o, count_o, 1'b1});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; stop_ok = 0 sends a low stop bit. The model
    // records the expected outcome and the edge the strobe is due on.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int start;
        start = cyc + 1;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = stop_ok;
        tick(CPB);
        rx_i = 1'b1;
        if (stop_ok) begin
            m_data  = b;
            m_count = m_count + 8'd1;
            exp_q.push_back('{start + LAT, m_data, m_count, 1'b0});
        end else begin
            exp_q.push_back('{start + LAT, m_data, m_count, 1'b1});
        end
    endtask

    // Wait until every expected strobe is due (plus margin), then compare.
    task automatic compare_events(input string tag);
        int last;
        int n;
        last = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].cyc : cyc;
        while (cyc < last + 4) tick(1);
        check({tag, "_nev"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_err"},  act_q[i].err,  exp_q[i].err);
            check({tag, "_data"}, act_q[i].data, exp_q[i].data);
            check({tag, "_cnt"},  act_q[i].cnt,  exp_q[i].cnt);
            check_range({tag, "_lat"}, act_q[i].cyc, exp_q[i].cyc - 1, exp_q[i].cyc + 1);
        end
    endtask

    task automatic clear_events();
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         b0;
        logic [7:0] b;

        // ---------------- reset / idle ----------------
        rst_n = 1'b0;
        ena   = 1'b1;
        rx_i  = 1'b1;
        tick(5);
        check("rst_data",  data_o,      8'h00);
        check("rst_valid", valid_o,     1'b0);
        check("rst_ferr",  frame_err_o, 1'b0);
        check("rst_busy",  busy_o,      1'b0);
        check("rst_count", count_o,     8'h00);
        rst_n = 1'b1;
        b0 = busy_cycles;
        tick(100);
        check("idle_busy_cycles", busy_cycles - b0, 0);
        check("idle_events", act_q.size(), 0);

        // ---------------- single byte ----------------
        send_frame(8'hA5, 1'b1);
        compare_events("single");
        check("single_data_o",  data_o,  8'hA5);
        check("single_count_o", count_o, 8'd1);
        clear_events();

        // ---------------- back-to-back ----------------
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        compare_events("b2b");
        if (act_q.size() == 3) begin
            check("b2b_gap01", act_q[1].cyc - act_q[0].cyc, 10 * CPB);
            check("b2b_gap12", act_q[2].cyc - act_q[1].cyc, 10 * CPB);
        end
        check("b2b_count_o", count_o, m_count);
        clear_events();

        // ---------------- glitch / false start ----------------
        tick(5);
        rx_i = 1'b0;
        tick(4);
        rx_i = 1'b1;
        check("glitch_busy_rise", busy_o, 1'b1);
        tick(3 * CPB);
        check("glitch_busy_clear", busy_o, 1'b0);
        check("glitch_events", act_q.size(), 0);
        check("glitch_data",   data_o,  m_data);
        check("glitch_count",  count_o, m_count);

        // ---------------- framing error, then recovery ----------------
        send_frame(8'h55, 1'b0);
        rx_i = 1'b1;
        tick(2 * CPB);
        send_frame(8'h12, 1'b1);
        compare_events("ferr");
        check("ferr_data_o", data_o, 8'h12);
        clear_events();

        // ---------------- random frames with random idle gaps ----------------
        for (int k = 0; k < 6; k++) begin
            send_frame(8'($urandom), 1'($urandom_range(0, 3) != 0));
            tick($urandom_range(0, 2 * CPB) + 2 * CPB);
        end
        compare_events("rand");
        clear_events();

        // Known non-zero byte so the reset check below is meaningful.
        send_frame(8'h81, 1'b1);
        compare_events("pre_abort");
        clear_events();
        tick(CPB);

        // ---------------- abort via ena at data bit 4 ----------------
        b = 8'($urandom);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = b[4];
        tick(CPB / 2);
        check("ena_busy_before", busy_o, 1'b1);
        ena = 1'b0;
        tick(1);
        check("ena_busy_after", busy_o, 1'b0);
        tick(CPB / 2 - 1);
        for (int i = 5; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = 1'b1;
        tick(2 * CPB);
        ena = 1'b1;
        tick(12 * CPB);
        check("ena_events", act_q.size(), 0);
        check("ena_data",   data_o,  m_data);
        check("ena_count",  count_o, m_count);
        check("ena_busy",   busy_o,  1'b0);

        // ---------------- reset mid-frame ----------------
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_i = 1'($urandom);
            tick(CPB);
        end
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_data",  data_o,      8'h00);
        check("rstmid_count", count_o,     8'h00);
        check("rstmid_busy",  busy_o,      1'b0);
        check("rstmid_valid", valid_o,     1'b0);
        check("rstmid_ferr",  frame_err_o, 1'b0);
        m_data  = 8'h00;
        m_count = 8'h00;
        rx_i = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(12 * CPB);
        check("rstmid_events", act_q.size(), 0);

        // ---------------- 256 good frames: count wraps ----------------
        for (int k = 0; k < 256; k++) begin
            send_frame(8'($urandom), 1'b1);
            tick($urandom_range(0, 3));
        end
        compare_events("wrap");
        check("wrap_count_o", count_o, 8'h00);
        check("wrap_data_o",  data_o,  m_data);
        clear_events();

        check("no_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_byte
